ex_mem_stage: RTL
=================

# ex_mem_stage

Pipeline stage directly downstream of the ALU. It registers the ALU result, flags and the instruction's side-band data into the EX/MEM boundary, and resolves conditional branches from the ALU `zero`/`pos` flags. On a taken branch it raises a one-cycle redirect and squashes the following `FLUSH_CYCLES` captured instructions. It also honours a downstream stall and keeps an architectural flag register for later consumers.

## Interface
- `FLUSH_CYCLES`, default 2: number of captured instructions squashed after a taken branch. Legal range 1..15.
- `clk`  input  1  — single clock, rising edge.
- `reset`  input  1  — asynchronous, active-low.
- `in_valid`  input  1  — an ALU result is present this cycle.
- `in_ready`  output  1  — stage can capture; equals `!stall`.
- `inst_id`  input  4  — opcode of the instruction in EX.
- `alu_out`  input  16  — ALU result.
- `zero`  input  1  — ALU zero flag.
- `pos`  input  1  — ALU positive (nonzero) flag.
- `rd`  input  4  — destination register index.
- `store_data`  input  16  — data for store.
- `branch_target`  input  16  — target PC computed in decode.
- `stall`  input  1  — downstream cannot accept.
- `out_valid`  output  1  — registered instruction valid.
- `out_inst_id`  output  4  — registered opcode.
- `out_result`  output  16  — registered `alu_out`.
- `out_store_data`  output  16  — registered `store_data`.
- `out_rd`  output  4  — registered `rd`.
- `out_wb`  output  1  — register write-back enable.
- `out_store`  output  1  — memory write enable.
- `flag_zero`, `flag_pos`  output  1 each — architectural flags.
- `branch_taken`  output  1  — one-cycle redirect pulse.
- `branch_pc`  output  16  — redirect target.
- `flush`  output  1  — high while in the FLUSH state.

## Operation
- Capture condition is `in_valid && !stall`. When `stall` is high, all `out_*` outputs, the flags, the FSM state and the counter hold.
- Opcode classes:
  - Branch: 1100 `beq` (taken if `zero`), 1101 `bne` (taken if `!zero`), 1110 `bgt` (taken if `pos`), 1111 `jmp` (always taken).
  - Store: 1010.
  - Everything else below 1100 is write-back.
- On capture of a non-squashed instruction:
  - `out_valid`=1, and all data fields are registered.
  - `out_wb` = write-back class.
  - `out_store` = (opcode==1010).
  - `flag_zero`/`flag_pos` load `zero`/`pos`.
- On capture of a squashed instruction:
  - `out_valid`, `out_wb`, `out_store` are 0.
  - Data fields are still registered.
  - Flags are unchanged and no branch is evaluated.
- Cycle with no capture and no stall: `out_valid`, `out_wb`, `out_store` go to 0 (bubble).
- FSM states:
  - RUN: a captured taken branch sets `branch_taken`=1 and `branch_pc`=`branch_target`, loads the counter with `FLUSH_CYCLES`, and moves to FLUSH. The branch itself still has `out_valid`=1 with `out_wb`=0 and `out_store`=0.
  - FLUSH: `flush`=1. Each capture is squashed and decrements the counter. The FSM returns to RUN on the capture that takes the counter to 0. Cycles with no capture do not decrement.
- A branch arriving while in FLUSH is squashed and never taken.
- `branch_pc` holds its last value when no branch is taken.

## Timing
- Latency is 1 cycle from capture edge to `out_*`.
- `branch_taken` is high for exactly the cycle after the capturing edge, then 0, even if `stall` rises in that cycle.
- `flush` rises in the same cycle as `branch_taken`. It falls in the cycle after the last squashed capture.
- `in_ready` is combinational from `stall`, with zero cycles of latency.
- Reset values, applied asynchronously on `reset`=0:
  - FSM=RUN, counter=0.
  - `out_valid`=0, `out_wb`=0, `out_store`=0, `branch_taken`=0, `flush`=0.
  - All 16/4-bit outputs =0.
  - `flag_zero`=1, `flag_pos`=0.
- Reset mid-FLUSH abandons the remaining squash count. The first capture after release is not squashed.
- Stall and branch at the same time: there is no capture, so no branch is evaluated. The instruction is evaluated when captured after `stall` drops.

## Test plan
- **Reset:** pull `reset` low mid-cycle. Every output goes to its reset value immediately (`flag_zero`=1, others 0), without waiting for a clock edge.
- **Add/store path:**
  - `inst_id`=0000, `alu_out`=0x1234, `rd`=3 → next cycle `out_valid`=1, `out_wb`=1, `out_result`=0x1234, `out_rd`=3, `flag_pos`=1.
  - `inst_id`=1010 → `out_store`=1, `out_wb`=0.
- **Taken `beq`:** `beq` with `zero`=1, `branch_target`=0x0040, followed by two valid adds → `branch_taken` pulse with `branch_pc`=0x0040. Both adds emerge with `out_valid`=0, the flags are unchanged, and the third add is valid.
- **Not-taken `bne` and `bgt`:** `bne` with `zero`=1, then `bgt` with `pos`=0 → no `branch_taken`, no `flush`, both valid with `out_wb`=0.
- **Stall during FLUSH:** after `jmp`, hold `stall`=1 for 3 cycles → outputs and counter frozen and `flush` stays 1. After release, exactly `FLUSH_CYCLES` captures are squashed.
- **Reset mid-FLUSH:** `jmp`, one squashed capture, assert `reset`, release, send an add → the add emerges with `out_valid`=1 and `flush`=0.

Source files
------------

// File: rtl/ex_mem_stage_if.sv
// ---------------------------------------------------------------------------
// ex_mem_stage_if : EX-side inputs and EX/MEM boundary outputs  | rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface ex_mem_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  inst_id;
  logic [15:0] alu_out;
  logic        zero;
  logic        pos;
  logic [3:0]  rd;
  logic [15:0] store_data;
  logic [15:0] branch_target;
  logic        stall;
  logic        out_valid;
  logic [3:0]  out_inst_id;
  logic [15:0] out_result;
  logic [15:0] out_store_data;
  logic [3:0]  out_rd;
  logic        out_wb;
  logic        out_store;
  logic        flag_zero;
  logic        flag_pos;
  logic        branch_taken;
  logic [15:0] branch_pc;
  logic        flush;

  modport master (
    output in_valid, inst_id, alu_out, zero, pos, rd, store_data, branch_target, stall,
    input  in_ready, out_valid, out_inst_id, out_result, out_store_data, out_rd,
           out_wb, out_store, flag_zero, flag_pos, branch_taken, branch_pc, flush
  );

  modport slave (
    input  in_valid, inst_id, alu_out, zero, pos, rd, store_data, branch_target, stall,
    output in_ready, out_valid, out_inst_id, out_result, out_store_data, out_rd,
           out_wb, out_store, flag_zero, flag_pos, branch_taken, branch_pc, flush
  );
endinterface

`default_nettype wire

// File: rtl/ex_mem_stage.sv
// ---------------------------------------------------------------------------
// ex_mem_stage : EX/MEM register, branch resolve and post-branch squash | rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ex_mem_stage #(
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  wire logic      clk,
  input  wire logic      rst_n,
  ex_mem_stage_if.slave  bus
);

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;

  localparam logic [3:0] OP_STORE = 4'b1010;
  localparam logic [3:0] OP_BEQ   = 4'b1100;
  localparam logic [3:0] OP_BNE   = 4'b1101;
  localparam logic [3:0] OP_BGT   = 4'b1110;
  localparam logic [3:0] OP_JMP   = 4'b1111;

  localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES);

  logic [0:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;

  logic        valid_q, wb_q, store_q;
  logic [3:0]  inst_q, rd_q;
  logic [15:0] result_q, sdata_q, bpc_q;
  logic        fzero_q, fpos_q, btaken_q;

  logic        capture, squash, cond_met, take, is_wb, is_store;

  assign capture  = bus.in_valid && !bus.stall;
  assign squash   = (state_q == ST_FLUSH);
  assign is_store = (bus.inst_id == OP_STORE);
  assign is_wb    = (bus.inst_id < OP_BEQ) && !is_store;

  always_comb begin
    cond_met = 1'b0;
    case (bus.inst_id)
      OP_BEQ:  cond_met = bus.zero;
      OP_BNE:  cond_met = !bus.zero;
      OP_BGT:  cond_met = bus.pos;
      OP_JMP:  cond_met = 1'b1;
      default: cond_met = 1'b0;
    endcase
  end

  // Only a live (non-squashed) captured branch can redirect.
  assign take = capture && !squash && cond_met;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_RUN: begin
        if (take) begin
          state_d = ST_FLUSH;
          cnt_d   = FLUSH_INIT;
        end
      end
      ST_FLUSH: begin
        if (capture) begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_RUN;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_comb begin
    bus.flush = (state_q == ST_FLUSH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      wb_q     <= 1'b0;
      store_q  <= 1'b0;
      inst_q   <= 4'd0;
      rd_q     <= 4'd0;
      result_q <= 16'd0;
      sdata_q  <= 16'd0;
      bpc_q    <= 16'd0;
      fzero_q  <= 1'b1;
      fpos_q   <= 1'b0;
      btaken_q <= 1'b0;
    end else begin
      // Redirect is a strict one-cycle pulse, independent of stall.
      btaken_q <= take;
      if (take) bpc_q <= bus.branch_target;
      if (!bus.stall) begin
        if (bus.in_valid) begin
          inst_q   <= bus.inst_id;
          rd_q     <= bus.rd;
          result_q <= bus.alu_out;
          sdata_q  <= bus.store_data;
          valid_q  <= !squash;
          wb_q     <= !squash && is_wb;
          store_q  <= !squash && is_store;
          if (!squash) begin
            fzero_q <= bus.zero;
            fpos_q  <= bus.pos;
          end
        end else begin
          valid_q <= 1'b0;
          wb_q    <= 1'b0;
          store_q <= 1'b0;
        end
      end
    end
  end

  assign bus.in_ready       = !bus.stall;
  assign bus.out_valid      = valid_q;
  assign bus.out_wb         = wb_q;
  assign bus.out_store      = store_q;
  assign bus.out_inst_id    = inst_q;
  assign bus.out_rd         = rd_q;
  assign bus.out_result     = result_q;
  assign bus.out_store_data = sdata_q;
  assign bus.flag_zero      = fzero_q;
  assign bus.flag_pos       = fpos_q;
  assign bus.branch_taken   = btaken_q;
  assign bus.branch_pc      = bpc_q;

endmodule

`default_nettype wire
